// File: rtl/hazard_ctrl_if.sv
// ============================================================================
//  hazard_ctrl_if
//  Decode-stage hazard interface. It bundles the ID-stage instruction, the
//  branch resolution from MEM, and the controller's stall, bubble, flush and
//  status outputs.
//
//  Signals:
//    id_valid      ID holds a real instruction          (pipeline -> ctrl)
//    id_instr[31:0] instruction currently in ID          (pipeline -> ctrl)
//    branch_taken  branch in MEM resolved taken          (pipeline -> ctrl)
//    stall         hold PC and IF/ID                     (ctrl -> pipeline)
//    bubble        insert NOP into ID/EX                 (ctrl -> pipeline)
//    flush         squash IF/ID and ID/EX                (ctrl -> pipeline)
//    halted        pipeline drained after HLT            (ctrl -> pipeline)
//    stall_count   saturating count of stall cycles      (ctrl -> pipeline)
//
//  Modports: master = pipeline side, slave = hazard controller.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             branch_taken;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid,
        output id_instr,
        output branch_taken,
        input  stall,
        input  bubble,
        input  flush,
        input  halted,
        input  stall_count
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  branch_taken,
        output stall,
        output bubble,
        output flush,
        output halted,
        output stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  hazard_ctrl
//  Hazard and sequencing controller for a 5-stage MIPS32 pipeline. It tracks
//  in-flight destination registers in a 3-slot scoreboard (ex, mem, wb),
//  stalls and bubbles on read-after-write hazards, flushes on a taken branch
//  and drains the pipeline after HLT.
//
//  Ports:
//    clk   pipeline clock, rising edge
//    rst   synchronous active-high reset
//    bus   hazard_ctrl_if.slave (id_valid, id_instr, branch_taken in;
//          stall, bubble, flush, halted, stall_count out)
//
//  Parameters:
//    CNT_W  width of the saturating stall-cycle counter (>= 2)
//
//  Optional feature macro:
//    HAZ_WB_BYPASS_EN  register file is write-first; the wb slot is excluded
//                      from hazard comparison (max stall 2 instead of 3).
//
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam logic [5:0] OP_RR_LO = 6'b000000;
    localparam logic [5:0] OP_RR_HI = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_RM_LO = 6'b001010;
    localparam logic [5:0] OP_RM_HI = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic             ex_valid;
    logic [4:0]       ex_reg;
    logic             mem_valid;
    logic [4:0]       mem_reg;
    logic             wb_valid;
    logic [4:0]       wb_reg;
    logic             halted_q;
    logic [CNT_W-1:0] stall_count_q;

    // ------------------------------------------------------------------
    // Instruction field extraction and decode
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reads_rs;
    logic       reads_rt;
    logic       writes;
    logic [4:0] dest;
    logic       is_hlt;

    assign opcode = bus.id_instr[31:26];
    assign rs     = bus.id_instr[25:21];
    assign rt     = bus.id_instr[20:16];
    assign rd     = bus.id_instr[15:11];

    // Immediate/shift bits carry no register information for hazards.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.id_instr[10:0];

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        writes   = 1'b0;
        dest     = 5'd0;
        is_hlt   = 1'b0;
        case (opcode) inside
            [OP_RR_LO:OP_RR_HI]: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                writes   = 1'b1;
                dest     = rd;
            end
            [OP_RM_LO:OP_RM_HI], OP_LW: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                dest     = rt;
            end
            OP_SW: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                reads_rs = 1'b1;
            end
            OP_HLT: begin
                is_hlt = 1'b1;
            end
            default: begin
                // Unknown opcodes neither read nor write.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // With a write-first register file the value being written back is
    // already visible to the reader in ID, so the wb slot never blocks.
    logic wb_cmp_valid;
`ifdef HAZ_WB_BYPASS_EN
    assign wb_cmp_valid = 1'b0;
`else
    assign wb_cmp_valid = wb_valid;
`endif

    logic rs_hit;
    logic rt_hit;
    logic hazard;
    logic flush;
    logic stall;
    logic accept;
    logic ex_next_valid;
    logic slots_empty;

    assign rs_hit = reads_rs && (rs != 5'd0) &&
                    ((ex_valid     && (ex_reg  == rs)) ||
                     (mem_valid    && (mem_reg == rs)) ||
                     (wb_cmp_valid && (wb_reg  == rs)));

    assign rt_hit = reads_rt && (rt != 5'd0) &&
                    ((ex_valid     && (ex_reg  == rt)) ||
                     (mem_valid    && (mem_reg == rt)) ||
                     (wb_cmp_valid && (wb_reg  == rt)));

    assign flush  = bus.branch_taken;

    // A taken branch squashes the ID instruction, so it cannot hazard.
    assign hazard = bus.id_valid && !flush && (rs_hit || rt_hit);

    assign stall  = hazard || (state != ST_RUN);

    // The ID instruction moves into EX this cycle.
    assign accept = bus.id_valid && !stall && !flush;

    // R0 is hard-wired to zero, so writes to it never need tracking.
    assign ex_next_valid = accept && writes && (dest != 5'd0);

    assign slots_empty = !ex_valid && !mem_valid && !wb_valid;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (accept && is_hlt) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A taken branch means the HLT was fetched on the wrong path.
                if (bus.branch_taken) begin
                    state_next = ST_RUN;
                end else if (slots_empty) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register, scoreboard and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            ex_valid      <= 1'b0;
            ex_reg        <= 5'd0;
            mem_valid     <= 1'b0;
            mem_reg       <= 5'd0;
            wb_valid      <= 1'b0;
            wb_reg        <= 5'd0;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state <= state_next;

            wb_valid <= mem_valid;
            wb_reg   <= mem_reg;

            // The instruction leaving EX is on the wrong path when flushing.
            mem_valid <= ex_valid && !flush;
            mem_reg   <= ex_reg;

            ex_valid <= ex_next_valid;
            ex_reg   <= ex_next_valid ? dest : 5'd0;

            halted_q <= (state_next == ST_HALT);

            if (stall && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall       = stall;
    assign bus.bubble      = stall;
    assign bus.flush       = flush;
    assign bus.halted      = halted_q;
    assign bus.stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  tb_hazard_ctrl
//  Directed-vector bench for hazard_ctrl. Two instances share the stimulus:
//  one with CNT_W=16 and one with CNT_W=2 to observe counter saturation.
//  Each vector pushes its hand-computed expected outputs into a queue, and an
//  independent monitor pops and compares on the falling clock edge.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam logic [31:0] I_ADDI_R1 = 32'h2801000a; // ADDI R1,R0,10
    localparam logic [31:0] I_ADD_R4  = 32'h00222000; // ADD  R4,R1,R2
    localparam logic [31:0] I_OR_R7   = 32'h0c003800; // OR   R7,R0,R0
    localparam logic [31:0] I_ADD_Z12 = 32'h00220000; // ADD  R0,R1,R2
    localparam logic [31:0] I_ADD_Z03 = 32'h00030000; // ADD  R0,R0,R3
    localparam logic [31:0] I_LW_R3   = 32'h20030000; // LW   R3,0(R0)
    localparam logic [31:0] I_SUB_R6  = 32'h04603000; // SUB  R6,R3,R0
    localparam logic [31:0] I_HLT     = 32'hfc000000; // HLT

    logic clk;
    logic rst;

    hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    hazard_ctrl_if #(.CNT_W(2))  bus_b ();

    hazard_ctrl #(.CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    hazard_ctrl #(.CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] flags;   // {stall, bubble, flush, halted}
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   vec_idx;

    // Drive one cycle of stimulus and queue its expected response.
    task automatic vec(input logic r, input logic v, input logic [31:0] ins,
                       input logic br, input logic st, input logic fl,
                       input logic ha, input int cnt);
        exp_t e;
        rst                = r;
        bus_a.id_valid     = v;
        bus_a.id_instr     = ins;
        bus_a.branch_taken = br;
        bus_b.id_valid     = v;
        bus_b.id_instr     = ins;
        bus_b.branch_taken = br;
        e.idx   = vec_idx;
        e.flags = {st, st, fl, ha};
        e.cnt   = cnt;
        exp_q.push_back(e);
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int cnt);
        for (int i = 0; i < n; i++) begin
            vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
        end
    endtask

    // Monitor: outputs are always present, so one expected entry per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [3:0] got_flags;
                int         exp_b;
                e = exp_q.pop_front();
                got_flags = {bus_a.stall, bus_a.bubble, bus_a.flush, bus_a.halted};
                n_cmp++;
                if (got_flags !== e.flags || int'(bus_a.stall_count) != e.cnt) begin
                    n_bad++;
                    $display("FAIL v%0d dut_a: got {stall,bubble,flush,halted}=%b cnt=%0d, expected %b cnt=%0d",
                             e.idx, got_flags, bus_a.stall_count, e.flags, e.cnt);
                end
                got_flags = {bus_b.stall, bus_b.bubble, bus_b.flush, bus_b.halted};
                exp_b = (e.cnt > 3) ? 3 : e.cnt;
                n_cmp++;
                if (got_flags !== e.flags || int'(bus_b.stall_count) != exp_b) begin
                    n_bad++;
                    $display("FAIL v%0d dut_b: got {stall,bubble,flush,halted}=%b cnt=%0d, expected %b cnt=%0d",
                             e.idx, got_flags, bus_b.stall_count, e.flags, exp_b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        vec_idx = 0;
        rst     = 1'b1;
        bus_a.id_valid = 1'b0; bus_a.id_instr = 32'h0; bus_a.branch_taken = 1'b0;
        bus_b.id_valid = 1'b0; bus_b.id_instr = 32'h0; bus_b.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //  rst   v     instr      br    stall flush halt  cnt
        // Reset state.
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Back-to-back RAW: 3 stall cycles.
        vec(1'b0, 1'b1, I_ADDI_R1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b1, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b1, 1'b0, 1'b0, 1);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b1, 1'b0, 1'b0, 2);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b0, 1'b0, 1'b0, 3);
        idle(3, 3);
        // Dependent instruction 3 cycles later: 1 stall (wb slot).
        vec(1'b0, 1'b1, I_ADDI_R1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        vec(1'b0, 1'b1, I_OR_R7,   1'b0, 1'b0, 1'b0, 1'b0, 3);
        vec(1'b0, 1'b1, I_OR_R7,   1'b0, 1'b0, 1'b0, 1'b0, 3);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b1, 1'b0, 1'b0, 3);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b0, 1'b0, 1'b0, 4);
        idle(3, 4);
        // R0 writes untracked: HLT then drains in one cycle.
        vec(1'b0, 1'b1, I_ADD_Z12, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        vec(1'b0, 1'b1, I_ADD_Z03, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        vec(1'b0, 1'b1, I_HLT,     1'b0, 1'b0, 1'b0, 1'b0, 4);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 4);
        // HALT sticky even with a branch; CNT_W=2 instance saturates.
        vec(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 1'b1, 5);
        vec(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 6);
        // After reset: halted and count cleared.
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Flush beats hazard; slots invalid afterwards.
        vec(1'b0, 1'b1, I_LW_R3,   1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b1, I_SUB_R6,  1'b1, 1'b0, 1'b1, 1'b0, 0);
        vec(1'b0, 1'b1, I_SUB_R6,  1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 0);
        // HLT squashed by branch: stays RUN.
        vec(1'b0, 1'b1, I_HLT,     1'b1, 1'b0, 1'b1, 1'b0, 0);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 0);
        // HLT after ADDI: 3 drain cycles, then HALT.
        vec(1'b0, 1'b1, I_ADDI_R1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b1, I_HLT,     1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 1);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 2);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 3);
        vec(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 4);
        vec(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 5);
        // DRAIN aborted by branch; wb slot still shifts and blocks.
        vec(1'b0, 1'b1, I_ADDI_R1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b1, I_HLT,     1'b0, 1'b0, 1'b0, 1'b0, 0);
        vec(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 1'b0, 0);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b1, 1'b0, 1'b0, 1);
        vec(1'b0, 1'b1, I_ADD_R4,  1'b0, 1'b0, 1'b0, 1'b0, 2);
        idle(3, 2);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
